// File: rtl/ysyx_23060025_hazard_unit_pkg.sv
// Shared definitions for the RAW hazard / bypass unit: FSM state encodings and default widths.
package ysyx_23060025_hazard_unit_pkg;

  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_NUM_STG = 3;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_RAW     = 5;
  localparam int DEF_CAW     = 12;
  localparam int DEF_CNT_W   = 32;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/ysyx_23060025_fwd_pick.sv
// Priority select of one read address across all producer stages; stage 0 (youngest) wins.
module ysyx_23060025_fwd_pick
  import ysyx_23060025_hazard_unit_pkg::*;
#(
  parameter int NUM_STG     = DEF_NUM_STG,
  parameter int AW          = DEF_RAW,
  parameter int XLEN        = DEF_XLEN,
  parameter bit ZERO_EXEMPT = 1'b1
) (
  input  logic                    rd_en,
  input  logic [AW-1:0]           raddr,
  input  logic [NUM_STG-1:0]      stg_busy,
  input  logic [NUM_STG-1:0]      stg_wen,
  input  logic [NUM_STG-1:0]      stg_rdy,
  input  logic [NUM_STG*AW-1:0]   stg_waddr,
  input  logic [NUM_STG*XLEN-1:0] stg_wdata,
  output logic                    hit,
  output logic                    rdy,
  output logic [XLEN-1:0]         data
);

  logic                 rd_valid;
  logic [NUM_STG-1:0]   match;

  // GPR x0 is hard-wired and never forwarded; CSR address 0 is an ordinary register.
  assign rd_valid = rd_en & (!ZERO_EXEMPT || (raddr != '0));

  always_comb begin
    match = '0;
    for (int s = 0; s < NUM_STG; s++) begin
      match[s] = rd_valid & stg_busy[s] & stg_wen[s] & (stg_waddr[s*AW +: AW] == raddr);
    end
  end

  // Walk oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      if (match[s]) begin
        hit  = 1'b1;
        rdy  = stg_rdy[s];
        data = stg_rdy[s] ? stg_wdata[s*XLEN +: XLEN] : '0;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060025_hazard_unit.sv
// RAW hazard and bypass unit between IDU and the downstream producer stages.
// Forwards ready results combinationally, stalls IDU on unresolved reads, counts stall/bypass events.
module ysyx_23060025_hazard_unit
  import ysyx_23060025_hazard_unit_pkg::*;
#(
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_STG = DEF_NUM_STG,
  parameter int XLEN    = DEF_XLEN,
  parameter int RAW     = DEF_RAW,
  parameter int CAW     = DEF_CAW,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    idu_busy_i,
  input  logic [NUM_RD-1:0]       idu_ren_i,
  input  logic [NUM_RD*RAW-1:0]   idu_raddr_i,
  input  logic                    idu_csr_ren_i,
  input  logic [CAW-1:0]          idu_csr_raddr_i,
  input  logic [NUM_STG-1:0]      stg_busy_i,
  input  logic [NUM_STG-1:0]      stg_wen_i,
  input  logic [NUM_STG*RAW-1:0]  stg_waddr_i,
  input  logic [NUM_STG*XLEN-1:0] stg_wdata_i,
  input  logic [NUM_STG-1:0]      stg_rdy_i,
  input  logic [NUM_STG-1:0]      stg_csr_wen_i,
  input  logic [NUM_STG*CAW-1:0]  stg_csr_waddr_i,
  input  logic [NUM_STG*XLEN-1:0] stg_csr_wdata_i,
  output logic [NUM_RD-1:0]       fwd_sel_o,
  output logic [NUM_RD*XLEN-1:0]  fwd_data_o,
  output logic                    csr_fwd_o,
  output logic [XLEN-1:0]         csr_fwd_data_o,
  output logic                    stall_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        stall_evt_o,
  output logic [CNT_W-1:0]        bypass_cnt_o
);

  logic [NUM_RD-1:0] gpr_hit;
  logic [NUM_RD-1:0] gpr_rdy;
  logic [NUM_RD-1:0] gpr_unres;
  logic              csr_hit;
  logic              csr_rdy;
  logic              csr_unres;
  logic              hazard;
  logic              enter_wait;
  logic              bypass_inc;
  hz_state_e         state_q;
  hz_state_e         state_d;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_gpr_pick
    logic [XLEN-1:0] pick_data;

    ysyx_23060025_fwd_pick #(
      .NUM_STG     (NUM_STG),
      .AW          (RAW),
      .XLEN        (XLEN),
      .ZERO_EXEMPT (1'b1)
    ) u_pick (
      .rd_en     (idu_busy_i & idu_ren_i[k]),
      .raddr     (idu_raddr_i[k*RAW +: RAW]),
      .stg_busy  (stg_busy_i),
      .stg_wen   (stg_wen_i),
      .stg_rdy   (stg_rdy_i),
      .stg_waddr (stg_waddr_i),
      .stg_wdata (stg_wdata_i),
      .hit       (gpr_hit[k]),
      .rdy       (gpr_rdy[k]),
      .data      (pick_data)
    );

    assign fwd_sel_o[k]                = gpr_hit[k] & gpr_rdy[k];
    assign gpr_unres[k]                = gpr_hit[k] & ~gpr_rdy[k];
    assign fwd_data_o[k*XLEN +: XLEN]  = pick_data;
  end

  ysyx_23060025_fwd_pick #(
    .NUM_STG     (NUM_STG),
    .AW          (CAW),
    .XLEN        (XLEN),
    .ZERO_EXEMPT (1'b0)
  ) u_csr_pick (
    .rd_en     (idu_busy_i & idu_csr_ren_i),
    .raddr     (idu_csr_raddr_i),
    .stg_busy  (stg_busy_i),
    .stg_wen   (stg_csr_wen_i),
    .stg_rdy   (stg_rdy_i),
    .stg_waddr (stg_csr_waddr_i),
    .stg_wdata (stg_csr_wdata_i),
    .hit       (csr_hit),
    .rdy       (csr_rdy),
    .data      (csr_fwd_data_o)
  );

  assign csr_fwd_o = csr_hit & csr_rdy;
  assign csr_unres = csr_hit & ~csr_rdy;

  assign hazard  = (|gpr_unres) | csr_unres;
  assign stall_o = hazard & ~flush_i;

  // A flushed hazard cycle must leave every counter untouched, including bypass.
  assign bypass_inc = (|fwd_sel_o) & ~hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    enter_wait = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (hazard && !flush_i) begin
          state_d    = HZ_WAIT;
          enter_wait = 1'b1;
        end
      end
      HZ_WAIT: begin
        if (flush_i || !hazard) state_d = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_o  <= '0;
      stall_evt_o  <= '0;
      bypass_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1))     stall_cnt_o  <= stall_cnt_o + 1'b1;
      if (enter_wait && (stall_evt_o != '1))  stall_evt_o  <= stall_evt_o + 1'b1;
      if (bypass_inc && (bypass_cnt_o != '1)) bypass_cnt_o <= bypass_cnt_o + 1'b1;
    end
  end

endmodule
